// File: rtl/note_lane_scroller_if.sv
// Lane scroller bundle: game control, chart spawn handshake,
// key presses, judgement pulses, counters and panel pixel maps.
interface note_lane_scroller_if;
  logic         enable;
  logic         clear;
  logic         spawn_valid;
  logic [6:0]   spawn_lanes;
  logic         spawn_ready;
  logic [6:0]   key_press;
  logic [6:0]   hit_lanes;
  logic [6:0]   miss_lanes;
  logic [9:0]   hit_count;
  logic [9:0]   miss_count;
  logic [191:0] notesMap0;
  logic [191:0] notesMap1;
  logic [191:0] notesMap2;
  logic [191:0] notesMap3;
  logic [191:0] notesMap4;
  logic [191:0] notesMap5;
  logic [191:0] notesMap6;

  modport master (
    output enable, clear, spawn_valid, spawn_lanes, key_press,
    input  spawn_ready, hit_lanes, miss_lanes, hit_count, miss_count,
    input  notesMap0, notesMap1, notesMap2, notesMap3,
    input  notesMap4, notesMap5, notesMap6
  );

  modport slave (
    input  enable, clear, spawn_valid, spawn_lanes, key_press,
    output spawn_ready, hit_lanes, miss_lanes, hit_count, miss_count,
    output notesMap0, notesMap1, notesMap2, notesMap3,
    output notesMap4, notesMap5, notesMap6
  );
endinterface

// File: rtl/note_lane_scroller.sv
// Seven scrolling note lanes with hit-window judgement at column 6
// and saturating hit/miss counters.
module note_lane_scroller #(
  parameter int unsigned TICK_DIV = 2500000,
  parameter int unsigned CNT_MAX  = 999
) (
  input logic              clk,
  input logic              rst,
  note_lane_scroller_if.slave bus
);
  localparam int unsigned TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  // Lane colours, lane 0 in the low bits.
  localparam logic [20:0] LANE_RGB = {
    3'b111, 3'b101, 3'b011, 3'b110, 3'b001, 3'b010, 3'b100
  };

  typedef struct packed {
    logic [63:0] occ;
    logic        hit;
    logic        miss;
  } lane_t;

  function automatic lane_t lane_step(
    input logic [63:0] occ,
    input logic        key,
    input logic        tk,
    input logic        spn
  );
    lane_t       r;
    logic [63:0] kept;
    kept  = occ;
    r.hit = key && (|occ[7:5]);
    if (r.hit) begin
      if (occ[6])      kept[6] = 1'b0;
      else if (occ[7]) kept[7] = 1'b0;
      else             kept[5] = 1'b0;
    end
    r.miss = tk && kept[5];
    r.occ  = kept;
    // The shift drops the column-5 note; it was judged a miss above.
    if (tk) begin
      r.occ    = {spn, kept[63:1]};
      r.occ[4] = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [9:0] sat_add(
    input logic [9:0] c,
    input logic [6:0] p
  );
    logic [10:0] s;
    s = {1'b0, c} + 11'($countones(p));
    return (s > 11'(CNT_MAX)) ? 10'(CNT_MAX) : s[9:0];
  endfunction

  logic [TW-1:0] tick_q, tick_d;
  logic [63:0]   occ_q [7];
  logic [63:0]   occ_d [7];
  logic [6:0]    hit_q, hit_d;
  logic [6:0]    miss_q, miss_d;
  logic          spawn_q, spawn_d;
  logic [9:0]    hcnt_q, hcnt_d;
  logic [9:0]    mcnt_q, mcnt_d;
  logic          tick;
  lane_t         nx [7];
  logic [191:0]  map [7];

  always_comb begin
    tick    = bus.enable && (tick_q == TICK_LAST);
    tick_d  = tick_q;
    spawn_d = 1'b0;
    hit_d   = '0;
    miss_d  = '0;
    hcnt_d  = sat_add(hcnt_q, hit_q);
    mcnt_d  = sat_add(mcnt_q, miss_q);
    for (int l = 0; l < 7; l++) begin
      nx[l] = lane_step(occ_q[l], bus.key_press[l], tick,
                        tick && bus.spawn_valid && bus.spawn_lanes[l]);
      occ_d[l] = occ_q[l];
    end
    if (bus.clear) begin
      tick_d = '0;
      hcnt_d = '0;
      mcnt_d = '0;
      for (int l = 0; l < 7; l++) occ_d[l] = '0;
    end else if (bus.enable) begin
      tick_d  = tick ? '0 : tick_q + 1'b1;
      spawn_d = tick && bus.spawn_valid;
      for (int l = 0; l < 7; l++) begin
        occ_d[l]  = nx[l].occ;
        hit_d[l]  = nx[l].hit;
        miss_d[l] = nx[l].miss;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q  <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
      spawn_q <= 1'b0;
      hcnt_q  <= '0;
      mcnt_q  <= '0;
      for (int l = 0; l < 7; l++) occ_q[l] <= '0;
    end else begin
      tick_q  <= tick_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      spawn_q <= spawn_d;
      hcnt_q  <= hcnt_d;
      mcnt_q  <= mcnt_d;
      for (int l = 0; l < 7; l++) occ_q[l] <= occ_d[l];
    end
  end

  always_comb begin
    for (int l = 0; l < 7; l++) begin
      map[l] = '0;
      for (int c = 0; c < 64; c++)
        if (occ_q[l][c]) map[l][3*c +: 3] = LANE_RGB[3*l +: 3];
    end
  end

  assign bus.spawn_ready = spawn_q;
  assign bus.hit_lanes   = hit_q;
  assign bus.miss_lanes  = miss_q;
  assign bus.hit_count   = hcnt_q;
  assign bus.miss_count  = mcnt_q;
  assign bus.notesMap0   = map[0];
  assign bus.notesMap1   = map[1];
  assign bus.notesMap2   = map[2];
  assign bus.notesMap3   = map[3];
  assign bus.notesMap4   = map[4];
  assign bus.notesMap5   = map[5];
  assign bus.notesMap6   = map[6];
endmodule

// File: tb/tb_note_lane_scroller.sv
// Directed bench for note_lane_scroller: queued expected pulses,
// independent monitor, direct checks of maps and counters.
module tb_note_lane_scroller;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  note_lane_scroller_if bus();

  note_lane_scroller #(
    .TICK_DIV(4),
    .CNT_MAX (999)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int errs   = 0;
  int checks = 0;
  int ph     = 0;
  logic [14:0] expq [$];

  localparam logic [14:0] EV_SPAWN = {1'b1, 14'd0};

  task automatic chk(input string nm, input logic [191:0] act,
                     input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [191:0] px(input int col, input logic [2:0] rgb);
    return 192'(rgb) << (3 * col);
  endfunction

  function automatic logic [191:0] all_maps();
    return bus.notesMap0 | bus.notesMap1 | bus.notesMap2 | bus.notesMap3 |
           bus.notesMap4 | bus.notesMap5 | bus.notesMap6;
  endfunction

  always @(negedge clk) begin
    logic [14:0] ev;
    ev = {bus.spawn_ready, bus.hit_lanes, bus.miss_lanes};
    if (ev != 15'd0) begin
      if (expq.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_pulse: got %0h want none", ev);
      end else begin
        chk("pulse", 192'(ev), 192'(expq.pop_front()));
      end
    end
  end

  task automatic cyc(input bit en, input bit clr, input bit sv,
                     input logic [6:0] sl, input logic [6:0] kp,
                     input logic [14:0] ev);
    bus.enable      = en;
    bus.clear       = clr;
    bus.spawn_valid = sv;
    bus.spawn_lanes = sl;
    bus.key_press   = kp;
    if (ev != 15'd0) expq.push_back(ev);
    @(posedge clk);
    #1;
    if (clr) ph = 0;
    else if (en) ph = (ph == 3) ? 0 : ph + 1;
    bus.clear       = 1'b0;
    bus.spawn_valid = 1'b0;
    bus.spawn_lanes = '0;
    bus.key_press   = '0;
  endtask

  task automatic to_tick();
    while (ph != 3) cyc(1, 0, 0, 7'd0, 7'd0, 15'd0);
  endtask

  task automatic tick(input bit sv, input logic [6:0] sl,
                      input logic [6:0] kp, input logic [14:0] ev);
    to_tick();
    cyc(1, 0, sv, sl, kp, ev);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int e;
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.clear = 1'b0;
    bus.spawn_valid = 1'b0;
    bus.spawn_lanes = '0;
    bus.key_press = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    ph = 0;
    chk("reset_maps", all_maps(), '0);
    chk("reset_hits", 192'(bus.hit_count), '0);
    chk("reset_miss", 192'(bus.miss_count), '0);

    tick(1, 7'b0000001, 7'd0, EV_SPAWN);
    chk("spawn_col63", bus.notesMap0, px(63, 3'b100));
    repeat (57) tick(0, 7'd0, 7'd0, 15'd0);
    chk("scroll_col6", bus.notesMap0, px(6, 3'b100));
    cyc(1, 1, 0, 7'd0, 7'd0, 15'd0);
    chk("clear_maps", all_maps(), '0);

    tick(1, 7'b0001000, 7'd0, EV_SPAWN);
    repeat (57) tick(0, 7'd0, 7'd0, 15'd0);
    chk("l3_col6", bus.notesMap3, px(6, 3'b110));
    cyc(1, 0, 0, 7'd0, 7'b0001000, {1'b0, 7'b0001000, 7'd0});
    chk("l3_hit_gone", bus.notesMap3, '0);
    cyc(1, 0, 0, 7'd0, 7'd0, 15'd0);
    chk("l3_hit_cnt", 192'(bus.hit_count), 192'(1));
    cyc(1, 0, 0, 7'd0, 7'b0001000, 15'd0);
    cyc(1, 0, 0, 7'd0, 7'd0, 15'd0);
    chk("empty_press_cnt", 192'(bus.hit_count), 192'(1));

    cyc(1, 1, 0, 7'd0, 7'd0, 15'd0);
    chk("clear_cnt", 192'(bus.hit_count), '0);
    tick(1, 7'b0000100, 7'd0, EV_SPAWN);
    repeat (58) tick(0, 7'd0, 7'd0, 15'd0);
    chk("l2_col5", bus.notesMap2, px(5, 3'b001));
    tick(0, 7'd0, 7'd0, {1'b0, 7'd0, 7'b0000100});
    chk("l2_miss_gone", bus.notesMap2, '0);
    cyc(1, 0, 0, 7'd0, 7'd0, 15'd0);
    chk("l2_miss_cnt", 192'(bus.miss_count), 192'(1));

    cyc(1, 1, 0, 7'd0, 7'd0, 15'd0);
    tick(1, 7'b0000010, 7'd0, EV_SPAWN);
    tick(0, 7'd0, 7'd0, 15'd0);
    tick(1, 7'b0000010, 7'd0, EV_SPAWN);
    repeat (56) tick(0, 7'd0, 7'd0, 15'd0);
    chk("l1_col5_7", bus.notesMap1,
        px(5, 3'b010) | px(7, 3'b010));
    tick(0, 7'd0, 7'b0000010, {1'b0, 7'b0000010, 7'b0000010});
    chk("l1_empty", bus.notesMap1, '0);
    cyc(1, 0, 0, 7'd0, 7'd0, 15'd0);
    chk("l1_hit_cnt", 192'(bus.hit_count), 192'(1));
    chk("l1_miss_cnt", 192'(bus.miss_count), 192'(1));

    cyc(1, 1, 0, 7'd0, 7'd0, 15'd0);
    for (int j = 1; j <= 58; j++)
      tick(1, 7'b0010001, 7'd0, EV_SPAWN);
    for (int i = 1; i <= 501; i++) begin
      to_tick();
      if (i == 1 || i >= 500) begin
        e = (2 * (i - 1) > 999) ? 999 : 2 * (i - 1);
        chk("sat_run", 192'(bus.hit_count), 192'(e));
      end
      cyc(1, 0, 1, 7'b0010001, 7'b0010001,
          {1'b1, 7'b0010001, 7'd0});
    end
    cyc(1, 0, 0, 7'd0, 7'd0, 15'd0);
    chk("sat_hold", 192'(bus.hit_count), 192'(999));
    chk("sat_nomiss", 192'(bus.miss_count), '0);

    cyc(1, 0, 0, 7'd0, 7'b0010001, 15'd0);
    chk("pre_rst_hit", 192'(bus.hit_lanes), 192'(7'b0010001));
    #2 rst = 1'b1;
    #1;
    chk("rst_maps", all_maps(), '0);
    chk("rst_hits", 192'(bus.hit_count), '0);
    chk("rst_pulse", 192'(bus.hit_lanes), '0);
    @(posedge clk);
    #1 rst = 1'b0;
    ph = 0;

    tick(1, 7'b0100000, 7'd0, EV_SPAWN);
    repeat (10) tick(0, 7'd0, 7'd0, 15'd0);
    repeat (2) cyc(1, 0, 0, 7'd0, 7'd0, 15'd0);
    chk("l5_col53", bus.notesMap5, px(53, 3'b101));
    repeat (20) cyc(0, 0, 1, 7'b0100000, 7'b1111111, 15'd0);
    chk("freeze_map", bus.notesMap5, px(53, 3'b101));
    cyc(1, 0, 0, 7'd0, 7'd0, 15'd0);
    chk("freeze_cnt", bus.notesMap5, px(53, 3'b101));
    cyc(1, 0, 0, 7'd0, 7'd0, 15'd0);
    chk("resume_tick", bus.notesMap5, px(52, 3'b101));
    cyc(1, 1, 0, 7'd0, 7'd0, 15'd0);
    chk("final_clear", all_maps(), '0);

    repeat (2) cyc(1, 0, 0, 7'd0, 7'd0, 15'd0);
    chk("queue_empty", 192'(expq.size()), '0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
